// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_ctrl_pkg
// Brief   : Control word bit map and sequencer state encoding for the 8-bit CPU.
// Revision: 1.0
// ============================================================================
package cpu_ctrl_pkg;

  localparam int CW_WIDTH_DEF = 24;

  localparam int CW_HLT  = 0;
  localparam int CW_MI   = 1;
  localparam int CW_RI   = 2;
  localparam int CW_RO   = 3;
  localparam int CW_IO   = 4;
  localparam int CW_II   = 5;
  localparam int CW_REGI = 6;
  localparam int CW_REGO = 7;
  localparam int CW_EO   = 8;
  localparam int CW_SU   = 9;
  localparam int CW_BI   = 10;
  localparam int CW_OI   = 11;
  localparam int CW_CE   = 12;
  localparam int CW_CO   = 13;
  localparam int CW_J    = 14;
  localparam int CW_FI   = 15;
  localparam int CW_IOM  = 16;
  localparam int CW_IIM  = 17;
  localparam int CW_IOA  = 18;
  localparam int CW_IIA  = 19;
  localparam int CW_XI   = 20;
  localparam int CW_SPJ  = 21;
  localparam int CW_BPI  = 22;
  localparam int CW_BPO  = 23;

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/ucode_ram.sv
`default_nettype none
// ============================================================================
// Module  : ucode_ram
// Brief   : Microcode store, synchronous write / asynchronous read, no reset.
// Revision: 1.0
// ============================================================================
module ucode_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // A read of the address being written sees the pre-edge contents.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : control_sequencer
// Brief   : Microcoded step sequencer with halt/resume, single step, ucode load.
// Revision: 1.0
// ============================================================================
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int CW_WIDTH     = CW_WIDTH_DEF,
  parameter int OPCODE_WIDTH = 4,
  parameter int FLAG_WIDTH   = 2,
  parameter int STEP_WIDTH   = 3,
  parameter int NUM_STEPS    = 5,
  parameter int HLT_BIT      = 0
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [OPCODE_WIDTH-1:0]                    opcode,
  input  logic [FLAG_WIDTH-1:0]                      flags,
  input  logic                                       step_mode,
  input  logic                                       step_req,
  input  logic                                       resume,
  input  logic                                       ucode_we,
  input  logic [FLAG_WIDTH+OPCODE_WIDTH+STEP_WIDTH-1:0] ucode_addr,
  input  logic [CW_WIDTH-1:0]                        ucode_wdata,
  output logic [CW_WIDTH-1:0]                        control_out,
  output logic [STEP_WIDTH-1:0]                      step,
  output logic                                       halted,
  output logic                                       instr_done
);

  localparam int ADDR_WIDTH = FLAG_WIDTH + OPCODE_WIDTH + STEP_WIDTH;
  localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(NUM_STEPS - 1);

  seq_state_t              r_state, w_state_nxt;
  logic [CW_WIDTH-1:0]     r_control_out, w_control_nxt, w_rd_data;
  logic [STEP_WIDTH-1:0]   r_step, w_step_nxt, w_run_step, w_rd_step;
  logic                    r_halted, w_halted_nxt;
  logic                    r_instr_done, w_done_nxt;
  logic                    w_adv;
  logic [ADDR_WIDTH-1:0]   w_rd_addr;

  assign w_adv = !step_mode || step_req;

  // A zero control word ends the instruction early, as does the last step.
  assign w_run_step = ((r_step == LAST_STEP) || (r_control_out == '0)) ?
                      '0 : r_step + STEP_WIDTH'(1);
  assign w_rd_step  = (r_state == ST_RUN) ? w_run_step : '0;
  assign w_rd_addr  = {flags, opcode, w_rd_step};

  ucode_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (CW_WIDTH)
  ) u_ucode_ram (
    .clk       (clk),
    .i_we      (ucode_we),
    .i_wr_addr (ucode_addr),
    .i_wr_data (ucode_wdata),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_control_nxt = r_control_out;
    w_step_nxt    = r_step;
    w_halted_nxt  = r_halted;
    w_done_nxt    = 1'b0;
    unique case (r_state)
      ST_PRIME: begin
        if (w_adv) begin
          w_control_nxt = w_rd_data;
          w_state_nxt   = ST_RUN;
        end
      end
      ST_RUN: begin
        // HLT takes effect on the next edge whether or not we are advancing.
        if (r_control_out[HLT_BIT]) begin
          w_control_nxt          = '0;
          w_control_nxt[HLT_BIT] = 1'b1;
          w_halted_nxt           = 1'b1;
          w_state_nxt            = ST_HALT;
        end else if (w_adv) begin
          w_step_nxt    = w_run_step;
          w_control_nxt = w_rd_data;
          w_done_nxt    = (w_run_step == '0);
        end
      end
      ST_HALT: begin
        if (resume) begin
          w_step_nxt   = '0;
          w_halted_nxt = 1'b0;
          w_state_nxt  = ST_PRIME;
        end
      end
      default: begin
        w_state_nxt = ST_PRIME;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_PRIME;
      r_control_out <= '0;
      r_step        <= '0;
      r_halted      <= 1'b0;
      r_instr_done  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_control_out <= w_control_nxt;
      r_step        <= w_step_nxt;
      r_halted      <= w_halted_nxt;
      r_instr_done  <= w_done_nxt;
    end
  end

  assign control_out = r_control_out;
  assign step        = r_step;
  assign halted      = r_halted;
  assign instr_done  = r_instr_done;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_sequencer
// Brief   : Directed table-driven bench for control_sequencer.
// Revision: 1.0
// ============================================================================
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [1:0]  flags;
  logic        step_mode, step_req, resume, ucode_we;
  logic [8:0]  ucode_addr;
  logic [23:0] ucode_wdata;
  logic [23:0] control_out;
  logic [2:0]  step;
  logic        halted, instr_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  control_sequencer #(
    .CW_WIDTH(24), .OPCODE_WIDTH(4), .FLAG_WIDTH(2),
    .STEP_WIDTH(3), .NUM_STEPS(5), .HLT_BIT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .flags(flags),
    .step_mode(step_mode), .step_req(step_req), .resume(resume),
    .ucode_we(ucode_we), .ucode_addr(ucode_addr), .ucode_wdata(ucode_wdata),
    .control_out(control_out), .step(step), .halted(halted),
    .instr_done(instr_done)
  );

  typedef struct {
    bit        rst;
    bit [3:0]  op;
    bit [1:0]  fl;
    bit        sm, rq, rs;
    bit [23:0] cw;
    bit [2:0]  st;
    bit        hl, dn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit [3:0] op, input bit [1:0] fl,
                     input bit sm, input bit rq, input bit rs,
                     input bit [23:0] cw, input bit [2:0] st,
                     input bit hl, input bit dn);
    vec_t v;
    v.rst = r; v.op = op; v.fl = fl; v.sm = sm; v.rq = rq; v.rs = rs;
    v.cw = cw; v.st = st; v.hl = hl; v.dn = dn;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [23:0] cw, input logic [2:0] st,
                         input logic hl, input logic dn);
    chk({tag, ".control_out"}, 32'(control_out), 32'(cw));
    chk({tag, ".step"},        32'(step),        32'(st));
    chk({tag, ".halted"},      32'(halted),      32'(hl));
    chk({tag, ".instr_done"},  32'(instr_done),  32'(dn));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] f, input logic [3:0] op, input logic [2:0] s,
                    input logic [23:0] d);
    ucode_we    = 1'b1;
    ucode_addr  = {f, op, s};
    ucode_wdata = d;
    tick();
    ucode_we    = 1'b0;
  endtask

  task automatic load5(input logic [1:0] f, input logic [3:0] op,
                       input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2,
                       input logic [23:0] w3, input logic [23:0] w4);
    wr(f, op, 3'd0, w0);
    wr(f, op, 3'd1, w1);
    wr(f, op, 3'd2, w2);
    wr(f, op, 3'd3, w3);
    wr(f, op, 3'd4, w4);
  endtask

  initial begin
    logic [23:0] seq_cw [0:5];
    logic [2:0]  seq_st [0:5];
    seq_cw = '{24'h002000, 24'h001028, 24'h000012, 24'h000104, 24'h000840, 24'h002000};
    seq_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

    rst_n = 1'b1; opcode = 4'd0; flags = 2'd0;
    step_mode = 1'b0; step_req = 1'b0; resume = 1'b0;
    ucode_we = 1'b0; ucode_addr = '0; ucode_wdata = '0;
    #1 rst_n = 1'b0;
    #1 chk_out("reset_async", 24'h0, 3'd0, 1'b0, 1'b0);

    load5(2'b00, 4'd0, 24'h002000, 24'h0, 24'h0, 24'h0, 24'h0);
    load5(2'b00, 4'd1, 24'h002000, 24'h001028, 24'h000012, 24'h000104, 24'h000840);
    load5(2'b00, 4'd3, 24'h002000, 24'h001028, 24'h000012, 24'h000000, 24'h0000FF);
    load5(2'b01, 4'd7, 24'h002000, 24'h001028, 24'h004000, 24'h000104, 24'h000840);
    load5(2'b00, 4'd7, 24'h002000, 24'h001028, 24'h000000, 24'h000104, 24'h000840);
    load5(2'b00, 4'd5, 24'h002000, 24'h001028, 24'h000001, 24'h000104, 24'h000840);
    chk_out("reset_held", 24'h0, 3'd0, 1'b0, 1'b0);

    rst_n = 1'b1;
    tick();
    chk_out("reset_release", 24'h002000, 3'd0, 1'b0, 1'b0);

    // Fetch/execute, opcode 1; one row also raises step_req in free run.
    add(1, 4'd1, 2'b00, 0, 0, 0, 24'h002000, 3'd0, 0, 0);
    add(0, 4'd1, 2'b00, 0, 0, 0, 24'h001028, 3'd1, 0, 0);
    add(0, 4'd1, 2'b00, 0, 1, 0, 24'h000012, 3'd2, 0, 0);
    add(0, 4'd1, 2'b00, 0, 0, 0, 24'h000104, 3'd3, 0, 0);
    add(0, 4'd1, 2'b00, 0, 0, 0, 24'h000840, 3'd4, 0, 0);
    add(0, 4'd1, 2'b00, 0, 0, 0, 24'h002000, 3'd0, 0, 1);
    add(0, 4'd1, 2'b00, 0, 0, 0, 24'h001028, 3'd1, 0, 0);
    // Early termination, opcode 3.
    add(1, 4'd3, 2'b00, 0, 0, 0, 24'h002000, 3'd0, 0, 0);
    add(0, 4'd3, 2'b00, 0, 0, 0, 24'h001028, 3'd1, 0, 0);
    add(0, 4'd3, 2'b00, 0, 0, 0, 24'h000012, 3'd2, 0, 0);
    add(0, 4'd3, 2'b00, 0, 0, 0, 24'h000000, 3'd3, 0, 0);
    add(0, 4'd3, 2'b00, 0, 0, 0, 24'h002000, 3'd0, 0, 1);
    add(0, 4'd3, 2'b00, 0, 0, 0, 24'h001028, 3'd1, 0, 0);
    // Flag addressing, opcode 7.
    add(1, 4'd7, 2'b01, 0, 0, 0, 24'h002000, 3'd0, 0, 0);
    add(0, 4'd7, 2'b01, 0, 0, 0, 24'h001028, 3'd1, 0, 0);
    add(0, 4'd7, 2'b01, 0, 0, 0, 24'h004000, 3'd2, 0, 0);
    add(0, 4'd7, 2'b01, 0, 0, 0, 24'h000104, 3'd3, 0, 0);
    add(1, 4'd7, 2'b00, 0, 0, 0, 24'h002000, 3'd0, 0, 0);
    add(0, 4'd7, 2'b00, 0, 0, 0, 24'h001028, 3'd1, 0, 0);
    add(0, 4'd7, 2'b00, 0, 0, 0, 24'h000000, 3'd2, 0, 0);
    add(0, 4'd7, 2'b00, 0, 0, 0, 24'h002000, 3'd0, 0, 1);
    // Single step, opcode 1; the last two requests form a two-cycle pulse.
    add(1, 4'd1, 2'b00, 1, 0, 0, 24'h000000, 3'd0, 0, 0);
    add(0, 4'd1, 2'b00, 1, 1, 0, 24'h002000, 3'd0, 0, 0);
    add(0, 4'd1, 2'b00, 1, 0, 0, 24'h002000, 3'd0, 0, 0);
    add(0, 4'd1, 2'b00, 1, 0, 0, 24'h002000, 3'd0, 0, 0);
    add(0, 4'd1, 2'b00, 1, 1, 0, 24'h001028, 3'd1, 0, 0);
    add(0, 4'd1, 2'b00, 1, 0, 0, 24'h001028, 3'd1, 0, 0);
    add(0, 4'd1, 2'b00, 1, 0, 0, 24'h001028, 3'd1, 0, 0);
    add(0, 4'd1, 2'b00, 1, 1, 0, 24'h000012, 3'd2, 0, 0);
    add(0, 4'd1, 2'b00, 1, 1, 0, 24'h000104, 3'd3, 0, 0);
    add(0, 4'd1, 2'b00, 1, 0, 0, 24'h000104, 3'd3, 0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      opcode = tbl[i].op; flags = tbl[i].fl;
      step_mode = tbl[i].sm; step_req = tbl[i].rq; resume = tbl[i].rs;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].cw, tbl[i].st, tbl[i].hl, tbl[i].dn);
    end
    step_req = 1'b0;

    // Asynchronous reset at step 3, then microcode must survive it.
    #2 rst_n = 1'b0;
    #1 chk_out("reset_mid", 24'h0, 3'd0, 1'b0, 1'b0);
    step_mode = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out($sformatf("after_reset%0d", k), seq_cw[k], seq_st[k], 1'b0, (k == 5));
    end

    // Halt at step 2 of opcode 5, hold, then resume together with step_req.
    rst_n = 1'b0; opcode = 4'd5; flags = 2'b00;
    tick();
    rst_n = 1'b1;
    tick(); chk_out("hlt_s0", 24'h002000, 3'd0, 1'b0, 1'b0);
    tick(); chk_out("hlt_s1", 24'h001028, 3'd1, 1'b0, 1'b0);
    tick(); chk_out("hlt_word", 24'h000001, 3'd2, 1'b0, 1'b0);
    tick(); chk_out("hlt_enter", 24'h000001, 3'd2, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_out($sformatf("hlt_hold%0d", k), 24'h000001, 3'd2, 1'b1, 1'b0);
    end
    resume = 1'b1; step_req = 1'b1;
    tick();
    resume = 1'b0; step_req = 1'b0;
    chk_out("resume", 24'h000001, 3'd0, 1'b0, 1'b0);
    tick(); chk_out("resume_prime", 24'h002000, 3'd0, 1'b0, 1'b0);
    tick(); chk_out("resume_run", 24'h001028, 3'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
